des_key_schedule: RTL and testbench
===================================

DES_KEY_SCHEDULE -- requirements
Module: des_key_schedule

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 SHALL expose the following ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; loads key and mode.
- key  in  [1:64]  DES key; parity bits 8,16,...,64 ignored.
- decrypt  in  1  mode, sampled with start; 1 = subkeys K16..K1.
- next  in  1  consumer has used current Kn; advance.
- Kn  out  [1:48]  current round subkey, feeds des_roundfunction Kn.
- round  out  [4:0]  current round number, 1..16; 0 when idle.
- valid  out  1  Kn/round hold a valid subkey.
- done  out  1  one-cycle pulse after round 16 is consumed.

Function
REQ-003 SHALL implement states IDLE and ACTIVE.
- IDLE -> ACTIVE on start.
- ACTIVE -> IDLE on next while round = 16.
REQ-004 On start, SHALL register C,D (28 bits each) = PC-1(key) and latch decrypt.
REQ-005 Encrypt round schedule:
- Round r uses C,D rotated left by cumulative shifts per table (1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1).
- Kn = PC-2(C,D).
REQ-006 Decrypt round schedule:
- Round 1 uses unrotated C0,D0 (= K16).
- Round r>1 rotates right by table entry (0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1)[r].
- Delivers K16..K1 in order.
REQ-007 Kn, round=1 and valid=1 SHALL appear exactly one cycle after start (latency 1).
REQ-008 next while valid and round<16 SHALL present round+1 and its Kn one cycle later, with valid held high.
REQ-009 next while valid and round=16 SHALL, one cycle later, set valid=0, round=0, done=1 for one cycle, Kn=0.
REQ-010 next while not valid SHALL be ignored.
REQ-011 Kn and round SHALL stay stable while valid and next=0, for any number of cycles.
REQ-012 start in ACTIVE SHALL abort and restart at round 1 with the new key/mode; start has priority over a simultaneous next.
REQ-013 start and done SHALL never yield done in the same cycle as a new round-1 valid; an aborted sequence SHALL not pulse done.
REQ-014 Kn SHALL be registered; no combinational path from key/next to Kn.

Reset
REQ-015 rst_n=0 SHALL immediately force: state IDLE, C=D=0, Kn=0, round=0, valid=0, done=0, mode=encrypt, including mid-sequence.
REQ-016 After rst_n release, the block SHALL ignore next and wait for start.

Structure
REQ-017 The PC-1 and PC-2 permutation tables and the 16-entry shift schedule SHALL live in a shared DES package, alongside the round-function E/P/S-box tables.
REQ-018 SHALL instantiate one combinational sub-module des_pc2 (56-bit C||D -> 48-bit Kn); the rotation and FSM stay in des_key_schedule.
REQ-019 Expected size is roughly 150-250 RTL lines.

Verification
REQ-020 Encrypt run: key=0x133457799BBCDFF1, decrypt=0, start, then next every cycle.
- Required: K1=0x1B02EFFC7072 at cycle 1, K2=0x79AED9DBC9E5, K16=0xCB3D8B0E17F5.
- Required: done one cycle after the 16th next.
REQ-021 Decrypt run: same key, decrypt=1.
- Required: round 1 Kn=0xCB3D8B0E17F5, round 16 Kn=0x1B02EFFC7072.
- Required: full sequence is the exact reverse of REQ-020.
REQ-022 Stall: hold next=0 for 5 cycles at round 3.
- Required: Kn=K3 and valid=1 stable throughout; the next advance yields K4.
REQ-023 Abort and reset:
- start with a new key at round 7 -> round 1 of the new key, no done.
- rst_n=0 at round 10 -> all outputs 0 immediately.
REQ-024 Integration: chain with des_roundfunction over 16 rounds, where the round start = valid and next = done_round.
- Required: with key=0x133457799BBCDFF1 and IP-permuted plaintext 0x0123456789ABCDEF, L16/R16 give ciphertext 0x85E813540F0AB405 after FP.
- Required: the decrypt run recovers the plaintext.

Source files
------------

// File: rtl/des_key_schedule_pkg.sv
// Shared DES constants: key-schedule permutations and shift schedules, plus the
// round-function E/P/S-box tables. Bit numbers follow DES convention (1 = MSB).
package des_key_schedule_pkg;

   typedef enum logic {IDLE, ACTIVE} ks_state_t;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // Entry r-1 is the rotation applied when stepping into round r.
   localparam logic [1:0] ENC_SHIFTS [16] = '{
      2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
   localparam logic [1:0] DEC_SHIFTS [16] = '{
      2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   localparam int E_TABLE [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_TABLE [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   // Each box is 64 nibbles, entry (row*16 + col) first-to-last from the MSB.
   localparam logic [255:0] SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FAB71E608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   function automatic logic [1:28] rot_left(input logic [1:28] x, input logic [1:0] n);
      case (n)
         2'd1:    return {x[2:28], x[1]};
         2'd2:    return {x[3:28], x[1:2]};
         default: return x;
      endcase
   endfunction

   function automatic logic [1:28] rot_right(input logic [1:28] x, input logic [1:0] n);
      case (n)
         2'd1:    return {x[28], x[1:27]};
         2'd2:    return {x[27:28], x[1:26]};
         default: return x;
      endcase
   endfunction

endpackage

// File: rtl/des_key_schedule_pc2.sv
// Permuted Choice 2: selects the 48 subkey bits from the rotated C||D halves.
module des_pc2
   import des_key_schedule_pkg::*;
(
   input  logic [1:56] cd,
   output logic [1:48] kn
);

   for (genvar i = 0; i < 48; i++) begin : g_pc2
      assign kn[i+1] = cd[PC2[i]];
   end

endmodule

// File: rtl/des_key_schedule.sv
// DES subkey sequencer: delivers K1..K16 (or K16..K1) one per consumer handshake,
// rotating C/D incrementally so only the current halves are held.
module des_key_schedule
   import des_key_schedule_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:64] key,
   input  logic        decrypt,
   input  logic        next,
   output logic [1:48] Kn,
   output logic [4:0]  round,
   output logic        valid,
   output logic        done
);

   ks_state_t   state, state_next;
   logic [1:28] c, d, c_next, d_next;
   logic [1:56] pc1_cd;
   logic [1:48] pc2_kn, kn_next;
   logic [4:0]  round_next;
   logic [1:0]  shift;
   logic        mode, mode_next, valid_next, done_next;

   for (genvar i = 0; i < 56; i++) begin : g_pc1
      assign pc1_cd[i+1] = key[PC1[i]];
   end

   // Subkey is taken from the halves being loaded, so Kn registers alongside C/D.
   des_pc2 u_pc2 (
      .cd ({c_next, d_next}),
      .kn (pc2_kn)
   );

   always_comb begin
      c_next = c;
      d_next = d;
      shift  = mode ? DEC_SHIFTS[round[3:0]] : ENC_SHIFTS[round[3:0]];
      if (start) begin
         c_next = decrypt ? pc1_cd[1:28]  : rot_left(pc1_cd[1:28], 2'd1);
         d_next = decrypt ? pc1_cd[29:56] : rot_left(pc1_cd[29:56], 2'd1);
      end else if (state == ACTIVE && next && round != 5'd16) begin
         c_next = mode ? rot_right(c, shift) : rot_left(c, shift);
         d_next = mode ? rot_right(d, shift) : rot_left(d, shift);
      end
   end

   // Start wins over next, which makes an abort silent (no done pulse).
   always_comb begin
      state_next = state;
      mode_next  = mode;
      round_next = round;
      valid_next = valid;
      done_next  = 1'b0;
      kn_next    = Kn;
      if (start) begin
         state_next = ACTIVE;
         mode_next  = decrypt;
         round_next = 5'd1;
         valid_next = 1'b1;
         kn_next    = pc2_kn;
      end else if (state == ACTIVE && next) begin
         if (round == 5'd16) begin
            state_next = IDLE;
            round_next = 5'd0;
            valid_next = 1'b0;
            done_next  = 1'b1;
            kn_next    = '0;
         end else begin
            round_next = round + 5'd1;
            kn_next    = pc2_kn;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         c     <= '0;
         d     <= '0;
         mode  <= 1'b0;
         round <= 5'd0;
         valid <= 1'b0;
         done  <= 1'b0;
         Kn    <= '0;
      end else begin
         state <= state_next;
         c     <= c_next;
         d     <= d_next;
         mode  <= mode_next;
         round <= round_next;
         valid <= valid_next;
         done  <= done_next;
         Kn    <= kn_next;
      end
   end

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule: scoreboarded subkey sequences plus a
// full 16-round DES encrypt/decrypt built around the delivered subkeys.
module tb_des_key_schedule;
   import des_key_schedule_pkg::*;

   localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_B = 64'h0E329232EA6D0D73;

   localparam int IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
      62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
      57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
      61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
   localparam int FP_T [64] = '{
      40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
      38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
      36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
      34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

   typedef struct packed {
      logic        valid;
      logic        done;
      logic [4:0]  round;
      logic [47:0] kn;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        decrypt = 1'b0;
   logic        next = 1'b0;
   logic [63:0] key = '0;
   logic [47:0] kn;
   logic [4:0]  round;
   logic        valid, done;
   int          errors = 0;
   int          checks = 0;
   exp_t        exp_q[$];

   always #5 clk = ~clk;

   des_key_schedule dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .key     (key),
      .decrypt (decrypt),
      .next    (next),
      .Kn      (kn),
      .round   (round),
      .valid   (valid),
      .done    (done)
   );

   // Reference subkey n built from scratch with the cumulative rotation count.
   function automatic logic [47:0] model_subkey(input logic [63:0] k, input int n);
      logic [55:0] cd;
      logic [27:0] c, d;
      logic [47:0] res;
      int          s = 0;
      for (int i = 0; i < 56; i++) cd[55-i] = k[6'(64 - PC1[i])];
      c = cd[55:28];
      d = cd[27:0];
      for (int j = 0; j < n; j++) s += int'(ENC_SHIFTS[4'(j)]);
      for (int j = 0; j < s; j++) begin
         c = {c[26:0], c[27]};
         d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) res[47-i] = cd[6'(56 - PC2[i])];
      return res;
   endfunction

   function automatic logic [47:0] exp_kn(input logic [63:0] k, input logic dec, input int r);
      return dec ? model_subkey(k, 17 - r) : model_subkey(k, r);
   endfunction

   function automatic exp_t mk_exp(input logic v, input logic dn, input logic [4:0] r,
                                   input logic [47:0] k);
      return {v, dn, r, k};
   endfunction

   function automatic logic [63:0] perm64(input logic [63:0] x, input logic final_perm);
      logic [63:0] y;
      for (int i = 0; i < 64; i++)
         y[63-i] = x[6'(64 - (final_perm ? FP_T[i] : IP_T[i]))];
      return y;
   endfunction

   function automatic logic [31:0] f_func(input logic [31:0] r, input logic [47:0] k);
      logic [47:0]  x;
      logic [31:0]  s_out, p;
      logic [5:0]   six;
      logic [5:0]   idx;
      logic [255:0] box;
      for (int i = 0; i < 48; i++) x[47-i] = r[5'(32 - E_TABLE[i])];
      x = x ^ k;
      for (int b = 0; b < 8; b++) begin
         six = x[47 - 6*b -: 6];
         idx = {six[5], six[0], six[4:1]};
         box = SBOX[3'(b)];
         s_out[31 - 4*b -: 4] = box[255 - 4*int'(idx) -: 4];
      end
      for (int i = 0; i < 32; i++) p[31-i] = s_out[5'(32 - P_TABLE[i])];
      return p;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      exp_t got;
      $display("[TB] reset state and idle next");
      got = {valid, done, round, kn};
      checks++;
      if (got !== mk_exp(1'b0, 1'b0, 5'd0, 48'h0)) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h want %h", got, mk_exp(1'b0, 1'b0, 5'd0, 48'h0));
      end
      next = 1'b1;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(mk_exp(1'b0, 1'b0, 5'd0, 48'h0));
         tick;
         got = {valid, done, round, kn};
         checks++;
         if (got !== exp_q.pop_front()) begin
            errors++;
            $display("[TB] FAIL idle_next%0d: got %h want all zero", i, got);
         end
      end
      next = 1'b0;
   endtask

   task automatic test_full_run(input logic dec);
      exp_t        e, got;
      logic [47:0] want;
      $display("[TB] full run, decrypt=%0b", dec);
      key = KEY_A; decrypt = dec; start = 1'b1; next = 1'b0;
      exp_q.push_back(mk_exp(1'b1, 1'b0, 5'd1, exp_kn(KEY_A, dec, 1)));
      tick;
      start = 1'b0; next = 1'b1;
      for (int r = 1; r <= 16; r++) begin
         e = exp_q.pop_front();
         got = {valid, done, round, kn};
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL run%0b_r%0d: got %h want %h", dec, r, got, e);
         end
         if (r == 1 || r == 16 || (r == 2 && !dec)) begin
            want = (r == 2) ? 48'h79AED9DBC9E5 :
                   ((r == 1) ^ dec) ? 48'h1B02EFFC7072 : 48'hCB3D8B0E17F5;
            checks++;
            if (kn !== want) begin
               errors++;
               $display("[TB] FAIL known_kn%0b_r%0d: got %h want %h", dec, r, kn, want);
            end
         end
         if (r < 16) exp_q.push_back(mk_exp(1'b1, 1'b0, 5'(r + 1), exp_kn(KEY_A, dec, r + 1)));
         else        exp_q.push_back(mk_exp(1'b0, 1'b1, 5'd0, 48'h0));
         tick;
      end
      e = exp_q.pop_front();
      got = {valid, done, round, kn};
      checks++;
      if (got !== e) begin
         errors++;
         $display("[TB] FAIL run%0b_done: got %h want %h", dec, got, e);
      end
      exp_q.push_back(mk_exp(1'b0, 1'b0, 5'd0, 48'h0));
      tick;
      got = {valid, done, round, kn};
      checks++;
      if (got !== exp_q.pop_front()) begin
         errors++;
         $display("[TB] FAIL run%0b_after_done: got %h want all zero", dec, got);
      end
      next = 1'b0;
   endtask

   task automatic test_stall;
      exp_t got;
      $display("[TB] stall at round 3");
      key = KEY_A; decrypt = 1'b0; start = 1'b1;
      exp_q.push_back(mk_exp(1'b1, 1'b0, 5'd1, exp_kn(KEY_A, 1'b0, 1)));
      tick;
      start = 1'b0;
      for (int step = 0; step < 9; step++) begin
         got = {valid, done, round, kn};
         checks++;
         if (got !== exp_q.pop_front()) begin
            errors++;
            $display("[TB] FAIL stall_step%0d: got r=%0d v=%b kn=%h", step, round, valid, kn);
         end
         // Advance 1->2->3, hold five cycles, then advance 3->4.
         next = (step < 2 || step == 7) ? 1'b1 : 1'b0;
         if (step < 2)       exp_q.push_back(mk_exp(1'b1, 1'b0, 5'(step + 2), exp_kn(KEY_A, 1'b0, step + 2)));
         else if (step < 7)  exp_q.push_back(mk_exp(1'b1, 1'b0, 5'd3, exp_kn(KEY_A, 1'b0, 3)));
         else if (step == 7) exp_q.push_back(mk_exp(1'b1, 1'b0, 5'd4, exp_kn(KEY_A, 1'b0, 4)));
         if (step < 8) tick;
      end
      next = 1'b0;
   endtask

   task automatic test_abort;
      exp_t e, got;
      $display("[TB] abort at round 7 with new key, start together with next");
      key = KEY_A; decrypt = 1'b0; start = 1'b1;
      tick;
      start = 1'b0; next = 1'b1;
      repeat (6) tick;
      next = 1'b0;
      checks++;
      if (round !== 5'd7 || kn !== exp_kn(KEY_A, 1'b0, 7)) begin
         errors++;
         $display("[TB] FAIL abort_pre: got r=%0d kn=%h want r=7 kn=%h", round, kn, exp_kn(KEY_A, 1'b0, 7));
      end
      key = KEY_B; decrypt = 1'b1; start = 1'b1; next = 1'b1;
      exp_q.push_back(mk_exp(1'b1, 1'b0, 5'd1, exp_kn(KEY_B, 1'b1, 1)));
      tick;
      start = 1'b0;
      for (int r = 1; r <= 16; r++) begin
         e = exp_q.pop_front();
         got = {valid, done, round, kn};
         checks++;
         if (got !== e) begin
            errors++;
            $display("[TB] FAIL abort_r%0d: got %h want %h", r, got, e);
         end
         if (r < 16) exp_q.push_back(mk_exp(1'b1, 1'b0, 5'(r + 1), exp_kn(KEY_B, 1'b1, r + 1)));
         else        exp_q.push_back(mk_exp(1'b0, 1'b1, 5'd0, 48'h0));
         tick;
      end
      e = exp_q.pop_front();
      got = {valid, done, round, kn};
      checks++;
      if (got !== e) begin
         errors++;
         $display("[TB] FAIL abort_done: got %h want %h", got, e);
      end
      next = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid;
      exp_t got;
      $display("[TB] reset at round 10");
      key = KEY_A; decrypt = 1'b1; start = 1'b1;
      tick;
      start = 1'b0; next = 1'b1;
      repeat (9) tick;
      next = 1'b0;
      checks++;
      if (round !== 5'd10 || valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_pre: got r=%0d v=%b want r=10 v=1", round, valid);
      end
      #2 rst_n = 1'b0;
      #1;
      got = {valid, done, round, kn};
      checks++;
      if (got !== mk_exp(1'b0, 1'b0, 5'd0, 48'h0)) begin
         errors++;
         $display("[TB] FAIL rst_immediate: got %h want all zero", got);
      end
      tick;
      tick;
      rst_n = 1'b1;
      next = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         got = {valid, done, round, kn};
         checks++;
         if (got !== mk_exp(1'b0, 1'b0, 5'd0, 48'h0)) begin
            errors++;
            $display("[TB] FAIL rst_ignore_next%0d: got %h want all zero", i, got);
         end
      end
      next = 1'b0;
      key = KEY_A; decrypt = 1'b0; start = 1'b1;
      tick;
      start = 1'b0;
      got = {valid, done, round, kn};
      checks++;
      if (got !== mk_exp(1'b1, 1'b0, 5'd1, 48'h1B02EFFC7072)) begin
         errors++;
         $display("[TB] FAIL rst_restart: got %h want r=1 kn=1b02effc7072", got);
      end
   endtask

   task automatic test_integration(input logic dec, input logic [63:0] din, input logic [63:0] want);
      logic [63:0] lr, dout;
      logic [31:0] l, r, tmp;
      $display("[TB] 16-round DES, decrypt=%0b", dec);
      key = KEY_A; decrypt = dec; start = 1'b1; next = 1'b0;
      tick;
      start = 1'b0;
      lr = perm64(din, 1'b0);
      l = lr[63:32];
      r = lr[31:0];
      for (int rnd = 1; rnd <= 16; rnd++) begin
         checks++;
         if (valid !== 1'b1 || round !== 5'(rnd)) begin
            errors++;
            $display("[TB] FAIL des%0b_round%0d: got v=%b r=%0d", dec, rnd, valid, round);
         end
         tmp = r;
         r = l ^ f_func(r, kn);
         l = tmp;
         next = 1'b1;
         tick;
         next = 1'b0;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL des%0b_done: got %b want 1", dec, done);
      end
      dout = perm64({r, l}, 1'b1);
      checks++;
      if (dout !== want) begin
         errors++;
         $display("[TB] FAIL des%0b_result: got %h want %h", dec, dout, want);
      end
      tick;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #23 rst_n = 1'b1;
      tick;
      test_reset;
      test_full_run(1'b0);
      test_full_run(1'b1);
      test_stall;
      test_abort;
      test_reset_mid;
      test_integration(1'b0, 64'h0123456789ABCDEF, 64'h85E813540F0AB405);
      test_integration(1'b1, 64'h85E813540F0AB405, 64'h0123456789ABCDEF);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
